bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (iterative shift-add-3, "double dabble") that sits directly upstream of the 8-digit seven-segment display driver. It accepts an unsigned binary value on a start strobe and converts it over `INPUT_WIDTH` shift cycles. It then presents the result as eight packed BCD nibbles, so the display shows decimal rather than hex. It also produces a per-digit leading-zero mask for blanking unused digits.

---
 rtl/bin_to_bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Feeds the 8-digit
// seven-segment driver with packed BCD digits and a leading-zero mask.

// Per-digit add-3 correction applied before each shift.
// Inputs never exceed 9, so the result always fits in 4 bits.
module bin_to_bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module bin_to_bcd_seq #(
  parameter int INPUT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] numero_binario,
  output logic [31:0]            bcd,
  output logic [7:0]             digit_enable,
  output logic                   valid,
  output logic                   busy
);
  localparam int NUM_DIGITS = 8;
  localparam int CW = (INPUT_WIDTH < 2) ? 1 : $clog2(INPUT_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] bin_q, bin_d;
  logic [31:0]            scratch_q, scratch_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [31:0]            bcd_q, bcd_d;
  logic [7:0]             den_q, den_d;
  logic                   valid_q, valid_d;

  logic [31:0]            scratch_adj;
  logic [7:0]             mask;

  // Each digit is corrected independently; no carry crosses a nibble.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bin_to_bcd_add3 u_add3 (
      .nib_i (scratch_q[g*4 +: 4]),
      .nib_o (scratch_adj[g*4 +: 4])
    );
  end

  // Leading-zero mask: digit i lit if it or any higher digit is nonzero.
  always_comb begin
    logic any;
    any  = 1'b0;
    mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any     = any | (|scratch_q[i*4 +: 4]);
      mask[i] = any;
    end
    mask[0] = 1'b1;
  end

  // Next-state and datapath: capture, INPUT_WIDTH shift steps, publish.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    den_d     = den_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = numero_binario;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        den_d   = mask;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partial conversion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      den_q     <= 8'h01;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      den_q     <= den_d;
      valid_q   <= valid_d;
    end
  end

  assign bcd          = bcd_q;
  assign digit_enable = den_q;
  assign valid        = valid_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default width plus a 26-bit instance.
module tb_bin_to_bcd_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num;
  logic [31:0] bcd;
  logic [7:0]  den;
  logic        valid, busy;

  logic        start_w;
  logic [25:0] num_w;
  logic [31:0] bcd_w;
  logic [7:0]  den_w;
  logic        valid_w, busy_w;

  int n_chk = 0;
  int n_fail = 0;

  bin_to_bcd_seq #(.INPUT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .start(start), .numero_binario(num),
    .bcd(bcd), .digit_enable(den), .valid(valid), .busy(busy)
  );

  bin_to_bcd_seq #(.INPUT_WIDTH(26)) u_dut_w (
    .clock(clock), .reset(reset), .start(start_w), .numero_binario(num_w),
    .bcd(bcd_w), .digit_enable(den_w), .valid(valid_w), .busy(busy_w)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One conversion on the 16-bit instance: latency, result and pulse width.
  task automatic run_conv(input string tag, input logic [15:0] v,
                          input logic [31:0] exp_bcd, input logic [7:0] exp_den);
    int lat;
    start = 1'b1; num = v;
    tick();
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_den"}, {24'h0, den}, {24'h0, exp_den});
    chk({tag, "_busy_drop"}, {31'h0, busy}, 32'h0);
    tick();
    chk({tag, "_vld_1cyc"}, {31'h0, valid}, 32'h0);
  endtask

  initial begin
    int lat, vcnt, bcnt;
    reset = 1'b1; start = 1'b0; num = '0; start_w = 1'b0; num_w = '0;
    repeat (3) tick();
    chk("rst_bcd", bcd, 32'h0);
    chk("rst_den", {24'h0, den}, 32'h01);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    tick();

    run_conv("zero", 16'd0, 32'h0000_0000, 8'h01);
    run_conv("max", 16'd65535, 32'h0006_5535, 8'h1F);
    run_conv("nine", 16'd9, 32'h0000_0009, 8'h01);
    run_conv("ten", 16'd10, 32'h0000_0010, 8'h03);
    run_conv("k1000", 16'd1000, 32'h0000_1000, 8'h0F);
    run_conv("k40000", 16'd40000, 32'h0004_0000, 8'h1F);

    // Busy: extra starts at cycles 3 and 17 must be ignored.
    start = 1'b1; num = 16'd1234;
    tick();
    start = 1'b0;
    vcnt = 0; bcnt = 0; lat = 0;
    for (int i = 1; i <= 30; i++) begin
      if (busy) bcnt++;
      start = (i == 3 || i == 17);
      if (start) num = 16'd9999;
      tick();
      start = 1'b0;
      if (valid) begin vcnt++; lat = i; end
    end
    chk("busy_bcd", bcd, 32'h0000_1234);
    chk("busy_den", {24'h0, den}, 32'h0F);
    chk("busy_vcnt", vcnt, 1);
    chk("busy_lat", lat, 17);
    chk("busy_cycles", bcnt, 17);

    // Reset mid-conversion: no result, no pulse.
    start = 1'b1; num = 16'd4321;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_bcd", bcd, 32'h0);
    chk("mrst_den", {24'h0, den}, 32'h01);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valid) vcnt++;
    end
    chk("mrst_novalid", vcnt, 0);
    run_conv("after_rst", 16'd7, 32'h0000_0007, 8'h01);

    // Back-to-back: start in the valid cycle of the previous conversion.
    start = 1'b1; num = 16'd100;
    tick();
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 60) begin tick(); lat++; end
    chk("b2b_lat1", lat, 17);
    chk("b2b_bcd1", bcd, 32'h0000_0100);
    chk("b2b_den1", {24'h0, den}, 32'h07);
    start = 1'b1; num = 16'd59999;
    tick();
    start = 1'b0;
    lat = 1;
    while (!valid && lat < 60) begin tick(); lat++; end
    chk("b2b_gap", lat, 18);
    chk("b2b_bcd2", bcd, 32'h0005_9999);
    chk("b2b_den2", {24'h0, den}, 32'h1F);
    tick();

    // Widest parameter.
    start_w = 1'b1; num_w = 26'd67108863;
    tick();
    start_w = 1'b0;
    lat = 0;
    while (!valid_w && lat < 80) begin tick(); lat++; end
    chk("wide_lat", lat, 27);
    chk("wide_bcd", bcd_w, 32'h6710_8863);
    chk("wide_den", {24'h0, den_w}, 32'hFF);
    tick();
    chk("wide_vld_1cyc", {31'h0, valid_w}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
